// File: rtl/illegal_inst_trap.sv
// rtl/illegal_inst_trap.sv - RISC-V illegal-instruction detector and trap requester
//
// Accepts one instruction per cycle in IDLE and decodes its legality. The
// registered result appears one cycle after acceptance. An illegal
// instruction moves the block to TRAP, where it raises an mcause=2 request
// to the CSR unit and holds it until the CSR unit acknowledges.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   inst_valid   inst/pc valid
//   inst_ready   block can accept (IDLE only)
//   inst         32-bit instruction word
//   pc           address of inst
//   res_valid    one-cycle pulse, result available
//   res_legal    registered legality of the accepted instruction
//   trap_req     illegal-instruction trap request
//   trap_cause   mcause (2) while trap_req, else 0
//   trap_tval    mtval (zero-extended inst) while trap_req, else 0
//   trap_epc     mepc (pc) while trap_req, else 0
//   trap_ack     CSR unit has taken the trap
//   illegal_cnt  saturating illegal-instruction count
module illegal_inst_trap #(
  parameter int XLEN   = 64,
  parameter bit EN_M   = 1'b1,
  parameter bit EN_CSR = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [31:0]      inst,
  input  logic [XLEN-1:0]  pc,
  output logic             res_valid,
  output logic             res_legal,
  output logic             trap_req,
  output logic [XLEN-1:0]  trap_cause,
  output logic [XLEN-1:0]  trap_tval,
  output logic [XLEN-1:0]  trap_epc,
  input  logic             trap_ack,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam bit              RV64          = (XLEN == 64);
  localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);

  typedef enum logic {IDLE, TRAP} state_t;

  state_t          state, state_nxt;
  logic            accept;
  logic            legal;
  logic [XLEN-1:0] tval_q;
  logic [XLEN-1:0] epc_q;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       shamt_ok;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  // RV32 shift amounts are 5 bits; imm[5]=1 is reserved there.
  assign shamt_ok = RV64 || !inst[25];

  // Legality decode: combinational in inst and parameters only.
  always_comb begin
    legal = 1'b0;
    if (inst[1:0] == 2'b11) begin
      case (opcode)
        7'b0110111, 7'b0010111, 7'b1101111: legal = 1'b1;            // lui, auipc, jal
        7'b1100111: legal = (f3 == 3'd0);                             // jalr
        7'b1100011: legal = (f3 != 3'd2) && (f3 != 3'd3);             // branches
        7'b0000011: legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                            (f3 == 3'd4) || (f3 == 3'd5) ||
                            (RV64 && ((f3 == 3'd3) || (f3 == 3'd6)));  // loads
        7'b0100011: legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                            (RV64 && (f3 == 3'd3));                   // stores
        7'b0010011: begin                                             // OP-IMM
          if (f3 == 3'd1)
            legal = (inst[31:26] == 6'h00) && shamt_ok;
          else if (f3 == 3'd5)
            legal = ((inst[31:26] == 6'h00) || (inst[31:26] == 6'h10)) && shamt_ok;
          else
            legal = 1'b1;
        end
        7'b0110011: begin                                             // OP
          if (f7 == 7'h00)
            legal = 1'b1;
          else if (f7 == 7'h20)
            legal = (f3 == 3'd0) || (f3 == 3'd5);
          else if (f7 == 7'h01)
            legal = EN_M;
          else
            legal = 1'b0;
        end
        7'b0001111: legal = (f3 == 3'd0);                             // fence
        7'b0011011: begin                                             // OP-IMM-32
          if (!RV64)
            legal = 1'b0;
          else if (f3 == 3'd0)
            legal = 1'b1;
          else if (f3 == 3'd1)
            legal = (f7 == 7'h00);
          else if (f3 == 3'd5)
            legal = (f7 == 7'h00) || (f7 == 7'h20);
          else
            legal = 1'b0;
        end
        7'b0111011: begin                                             // OP-32
          if (!RV64)
            legal = 1'b0;
          else if (f7 == 7'h00)
            legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd5);
          else if (f7 == 7'h20)
            legal = (f3 == 3'd0) || (f3 == 3'd5);
          else if (f7 == 7'h01)
            legal = EN_M && (f3 != 3'd1) && (f3 != 3'd2) && (f3 != 3'd3);
          else
            legal = 1'b0;
        end
        7'b1110011: begin                                             // SYSTEM
          if ((inst == 32'h0000_0073) || (inst == 32'h0010_0073))
            legal = 1'b1;
          else if (EN_CSR)
            legal = (inst == 32'h3020_0073) ||
                    ((f3 != 3'd0) && (f3 != 3'd4));
          else
            legal = 1'b0;
        end
        default: legal = 1'b0;
      endcase
    end
  end

  assign inst_ready = (state == IDLE);
  assign accept     = inst_valid && inst_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !legal) state_nxt = TRAP;
      TRAP:    if (trap_ack)         state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      res_valid   <= 1'b0;
      res_legal   <= 1'b0;
      tval_q      <= '0;
      epc_q       <= '0;
      illegal_cnt <= '0;
    end else begin
      state     <= state_nxt;
      res_valid <= accept;
      if (accept) begin
        res_legal <= legal;
        // Trap payload is captured only on illegal accepts so it stays
        // stable for the whole TRAP residency.
        if (!legal) begin
          tval_q <= XLEN'(inst);
          epc_q  <= pc;
          if (illegal_cnt != {CNT_W{1'b1}})
            illegal_cnt <= illegal_cnt + 1'b1;
        end
      end else begin
        res_legal <= 1'b0;
      end
    end
  end

  assign trap_req   = (state == TRAP);
  assign trap_cause = trap_req ? CAUSE_ILLEGAL : '0;
  assign trap_tval  = trap_req ? tval_q : '0;
  assign trap_epc   = trap_req ? epc_q : '0;

endmodule

// File: doc/illegal_inst_trap.md
ILLEGAL_INST_TRAP -- requirements
Module: illegal_inst_trap

Interface
REQ-001 SHALL have parameter XLEN, default 64: datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter EN_M, default 1: 1 = M extension (mul/div/rem, plus W forms when XLEN=64) is legal.
REQ-003 SHALL have parameter EN_CSR, default 1: 1 = Zicsr and mret are legal.
REQ-004 SHALL have parameter CNT_W, default 16: width of the illegal-instruction counter.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port inst_valid, input, 1: inst and pc are valid.
REQ-008 SHALL have port inst_ready, output, 1: block can accept an instruction.
REQ-009 SHALL have port inst, input, 32: instruction word.
REQ-010 SHALL have port pc, input, XLEN: address of inst.
REQ-011 SHALL have port res_valid, output, 1: one-cycle pulse; legality result available.
REQ-012 SHALL have port res_legal, output, 1: 1 = instruction legal; meaningful only while res_valid=1.
REQ-013 SHALL have port trap_req, output, 1: illegal-instruction trap request to the CSR unit.
REQ-014 SHALL have port trap_cause, output, XLEN: mcause value.
REQ-015 SHALL have port trap_tval, output, XLEN: mtval value.
REQ-016 SHALL have port trap_epc, output, XLEN: mepc value.
REQ-017 SHALL have port trap_ack, input, 1: CSR unit has taken the trap.
REQ-018 SHALL have port illegal_cnt, output, CNT_W: saturating count of illegal instructions.

Function
REQ-019 The instruction SHALL be accepted on a cycle with inst_valid=1 and inst_ready=1.
REQ-020 The FSM SHALL have states IDLE and TRAP; inst_ready=1 exactly in IDLE.
REQ-021 res_valid SHALL pulse for one cycle exactly one cycle after acceptance; res_legal SHALL be the registered legality of the accepted inst.
REQ-022 On an illegal accept, the FSM SHALL go to TRAP on the same edge that registers the result.
REQ-023 On a legal accept, the FSM SHALL stay in IDLE; back-to-back accepts SHALL give one result per cycle.
REQ-024 In TRAP:
- trap_req=1
- trap_cause=2
- trap_tval=inst zero-extended to XLEN
- trap_epc=pc
- all values SHALL be held stable until trap_ack=1.
REQ-025 trap_ack=1 in TRAP SHALL move the FSM to IDLE on that edge; trap_req=0 from the next cycle.
REQ-026 trap_ack SHALL be ignored in IDLE.
REQ-027 trap_cause, trap_tval and trap_epc SHALL be 0 whenever trap_req=0.
REQ-028 illegal_cnt SHALL increment by 1 at each illegal result and saturate at all-ones.
REQ-029 Legality SHALL require inst[1:0]=2'b11, plus one of the following encodings with exact funct3/funct7 matches:
- RV32I: lui, auipc, jal, jalr (funct3=0), branches (funct3 not 2 or 3), lb/lh/lw/lbu/lhu, sb/sh/sw, OP-IMM, OP, fence (funct3=0).
- OP-IMM shifts: imm[11:6]=0, except srai imm[11:6]=6'h10. When XLEN=32, imm[5]=1 is illegal.
- Only when XLEN=64: ld, lwu, sd, OP-IMM-32 (addiw, slliw/srliw/sraiw with imm[11:5]=0/0/0x20), OP-32 (addw, subw, sllw, srlw, sraw).
- Only when EN_M=1: funct7=0x01 in OP (all funct3), and in OP-32 for funct3 0,4,5,6,7 when XLEN=64.
- SYSTEM: ecall=0x00000073 and ebreak=0x00100073 are always legal.
- SYSTEM, only when EN_CSR=1: mret=0x30200073, and csrrw/csrrs/csrrc/csrrwi/csrrsi/csrrci (funct3 1,2,3,5,6,7).
- Everything else SHALL be illegal.
REQ-030 Legality decode SHALL be purely a function of inst and the parameters.

Reset
REQ-031 With rst_n=0 at a rising edge, the FSM SHALL enter IDLE; res_valid, res_legal, trap_req and illegal_cnt SHALL be 0; trap outputs SHALL be 0.
REQ-032 Reset SHALL override any pending trap, acceptance or trap_ack in the same cycle.
REQ-033 inst_ready SHALL be 1 in the first cycle after rst_n returns high.

Verification
REQ-034 Accept inst=0x00000413 -> next cycle: res_valid=1, res_legal=1, trap_req=0, illegal_cnt unchanged.
REQ-035 Accept inst=0x0000000B, pc=0x80000010 -> next cycle: res_legal=0, trap_req=1, trap_cause=2, trap_tval=0xB, trap_epc=0x80000010, inst_ready=0. Hold 3 cycles, pulse trap_ack -> IDLE next cycle, illegal_cnt=1.
REQ-036 XLEN=32: ld 0x00053503 and slli with imm[5]=1 (0x02051513) -> illegal. XLEN=64: both legal.
REQ-037 EN_M=0: mul 0x02B50533 -> illegal. EN_CSR=0: csrrs 0x300025F3 and mret -> illegal, ecall -> legal.
REQ-038 Assert rst_n=0 while in TRAP with trap_ack=1 -> trap_req=0, illegal_cnt=0 next cycle.
REQ-039 CNT_W=2, five illegal instructions each acked -> illegal_cnt sequence 1,2,3,3,3.
